// File: rtl/ula_pkg.sv
// Shared ALU definitions: operation codes (also used by the ALU control decoder)
// and the multi-cycle FSM state type.
package ula_pkg;

   localparam logic [4:0] ULA_AND  = 5'b00000;
   localparam logic [4:0] ULA_OR   = 5'b00001;
   localparam logic [4:0] ULA_ADD  = 5'b00010;
   localparam logic [4:0] ULA_SRL  = 5'b00011;
   localparam logic [4:0] ULA_MUL  = 5'b00100;
   localparam logic [4:0] ULA_DIV  = 5'b00101;
   localparam logic [4:0] ULA_SUB  = 5'b00110;
   localparam logic [4:0] ULA_SLT  = 5'b00111;
   localparam logic [4:0] ULA_LUI  = 5'b01000;
   localparam logic [4:0] ULA_REM  = 5'b01001;
   localparam logic [4:0] ULA_SGT  = 5'b01010;
   localparam logic [4:0] ULA_SGTE = 5'b01011;
   localparam logic [4:0] ULA_NOT  = 5'b01100;
   localparam logic [4:0] ULA_SEQ  = 5'b01101;
   localparam logic [4:0] ULA_SLL  = 5'b01110;
   localparam logic [4:0] ULA_SNEQ = 5'b01111;
   localparam logic [4:0] ULA_SLTE = 5'b10000;
   localparam logic [4:0] ULA_INV  = 5'b11111;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} ula_state_e;

endpackage

// File: rtl/ula_divisor.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per clock.
// o_done flags the final iteration; quotient/remainder are valid the cycle after.
module ula_divisor #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dvd,
   input  logic [WIDTH-1:0] i_dvs,
   output logic [WIDTH-1:0] o_quo,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_done
);
   localparam int CW = $clog2(WIDTH);

   logic             r_run;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_quo, r_rem, r_dvs;
   logic [WIDTH:0]   w_trial;

   // Dividend bits shift out of r_quo's MSB while quotient bits shift into its LSB
   assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
   assign o_done  = r_run & (r_cnt == CW'(WIDTH-1));
   assign o_quo   = r_quo;
   assign o_rem   = r_rem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run <= 1'b0;
         r_cnt <= '0;
         r_quo <= '0;
         r_rem <= '0;
         r_dvs <= '0;
      end else if (i_start) begin
         r_run <= 1'b1;
         r_cnt <= '0;
         r_quo <= i_dvd;
         r_rem <= '0;
         r_dvs <= i_dvs;
      end else if (r_run) begin
         if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
         end else begin
            r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
         end
         r_cnt <= r_cnt + 1'b1;
         if (o_done) r_run <= 1'b0;
      end
   end

endmodule

// File: rtl/ula_multiciclo.sv
// Execution-stage ALU: single-cycle simple ops, iterative mul (shift-add) and
// div/rem (restoring divider plus sign fix-up) with busy for pipeline stall.
module ula_multiciclo
   import ula_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [4:0]       ULActl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             done,
   output logic             busy,
   output logic             erro
);
   ula_state_e       r_st, w_nxt;
   logic [WIDTH-1:0] r_ma, r_mb, r_macc, r_res;
   logic [SHW-1:0]   r_cnt;
   logic             r_neg_q, r_neg_r, r_bz, r_is_rem, r_done, r_zero, r_erro;
   logic [WIDTH-1:0] w_simple, w_macc_nxt, w_fix, w_quo, w_rem, w_dvd_mag, w_dvs_mag;
   logic             w_valid, w_acc, w_is_mul, w_is_dv, w_mul_last, w_div_last;

   assign w_acc      = start & (r_st == S_IDLE);
   assign w_is_mul   = (ULActl == ULA_MUL);
   assign w_is_dv    = (ULActl == ULA_DIV) | (ULActl == ULA_REM);
   assign w_mul_last = (r_st == S_MUL) & (r_cnt == SHW'(WIDTH-1));
   assign w_macc_nxt = r_macc + (r_mb[0] ? r_ma : '0);
   assign w_dvd_mag  = A[WIDTH-1] ? (-A) : A;
   assign w_dvs_mag  = B[WIDTH-1] ? (-B) : B;

   always_comb begin
      w_simple = '0;
      w_valid  = 1'b1;
      case (ULActl)
         ULA_AND:  w_simple = A & B;
         ULA_OR:   w_simple = A | B;
         ULA_ADD:  w_simple = A + B;
         ULA_SUB:  w_simple = A - B;
         ULA_SLT:  w_simple[0] = $signed(A) <  $signed(B);
         ULA_SLTE: w_simple[0] = $signed(A) <= $signed(B);
         ULA_SGT:  w_simple[0] = $signed(A) >  $signed(B);
         ULA_SGTE: w_simple[0] = $signed(A) >= $signed(B);
         ULA_SEQ:  w_simple[0] = (A == B);
         ULA_SNEQ: w_simple[0] = (A != B);
         ULA_NOT:  w_simple = ~A;
         ULA_LUI:  w_simple = B << (WIDTH/2);
         ULA_SLL:  w_simple = A << B[SHW-1:0];
         ULA_SRL:  w_simple = A >> B[SHW-1:0];
         default:  w_valid  = 1'b0;
      endcase
   end

   // Division by zero keeps the all-ones quotient; remainder naturally returns A
   always_comb begin
      if (r_is_rem)  w_fix = r_neg_r ? (-w_rem) : w_rem;
      else if (r_bz) w_fix = '1;
      else           w_fix = r_neg_q ? (-w_quo) : w_quo;
   end

   always_comb begin
      w_nxt = r_st;
      case (r_st)
         S_IDLE: if (w_acc && w_is_mul) w_nxt = S_MUL;
                 else if (w_acc && w_is_dv) w_nxt = S_DIV;
         S_MUL:  if (w_mul_last) w_nxt = S_IDLE;
         S_DIV:  if (w_div_last) w_nxt = S_FIX;
         S_FIX:  w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_st <= S_IDLE;
      else        r_st <= w_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ma <= '0; r_mb <= '0; r_macc <= '0; r_cnt <= '0;
         r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_bz <= 1'b0; r_is_rem <= 1'b0;
      end else if (w_acc && w_is_mul) begin
         r_ma <= A; r_mb <= B; r_macc <= '0; r_cnt <= '0;
      end else if (w_acc && w_is_dv) begin
         r_neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
         r_neg_r  <= A[WIDTH-1];
         r_bz     <= (B == '0);
         r_is_rem <= (ULActl == ULA_REM);
      end else if (r_st == S_MUL) begin
         r_ma   <= r_ma << 1;
         r_mb   <= r_mb >> 1;
         r_macc <= w_macc_nxt;
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   // Every completion path refreshes result, zero and erro together with done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res <= '0; r_zero <= 1'b0; r_done <= 1'b0; r_erro <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_acc && !w_is_mul && !w_is_dv) begin
            r_res  <= w_simple;
            r_zero <= (w_simple == '0);
            r_erro <= ~w_valid;
            r_done <= 1'b1;
         end else if (w_mul_last) begin
            r_res  <= w_macc_nxt;
            r_zero <= (w_macc_nxt == '0);
            r_erro <= 1'b0;
            r_done <= 1'b1;
         end else if (r_st == S_FIX) begin
            r_res  <= w_fix;
            r_zero <= (w_fix == '0);
            r_erro <= 1'b0;
            r_done <= 1'b1;
         end
      end
   end

   ula_divisor #(.WIDTH(WIDTH)) u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_start(w_acc & w_is_dv),
      .i_dvd  (w_dvd_mag),
      .i_dvs  (w_dvs_mag),
      .o_quo  (w_quo),
      .o_rem  (w_rem),
      .o_done (w_div_last)
   );

   assign result = r_res;
   assign zero   = r_zero;
   assign done   = r_done;
   assign busy   = (r_st != S_IDLE);
   assign erro   = r_erro;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Randomized self-checking bench for ula_multiciclo against a plain-arithmetic model.
module tb_ula_multiciclo;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n, start, zero, done, busy, erro;
   logic [4:0]    ULActl;
   logic [W-1:0]  A, B, result;
   int            checks = 0, failures = 0;

   always #5 clk = ~clk;

   ula_multiciclo #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ULActl(ULActl), .A(A), .B(B),
      .result(result), .zero(zero), .done(done), .busy(busy), .erro(erro)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic e, output int lat);
      logic signed [31:0] sa, sb;
      sa = a; sb = b; r = '0; e = 1'b0; lat = 1;
      case (c)
         5'b00000: r = a & b;
         5'b00001: r = a | b;
         5'b00010: r = a + b;
         5'b00110: r = a - b;
         5'b00111: r = {31'b0, sa <  sb};
         5'b10000: r = {31'b0, sa <= sb};
         5'b01010: r = {31'b0, sa >  sb};
         5'b01011: r = {31'b0, sa >= sb};
         5'b01101: r = {31'b0, a == b};
         5'b01111: r = {31'b0, a != b};
         5'b01100: r = ~a;
         5'b01000: r = b << 16;
         5'b01110: r = a << b[4:0];
         5'b00011: r = a >> b[4:0];
         5'b00100: begin r = a * b; lat = 33; end
         5'b00101: begin
            lat = 34;
            if (b == '0) r = '1;
            else if (a == 32'h80000000 && b == '1) r = a;
            else r = sa / sb;
         end
         5'b01001: begin
            lat = 34;
            if (b == '0) r = a;
            else if (a == 32'h80000000 && b == '1) r = '0;
            else r = sa % sb;
         end
         default: e = 1'b1;
      endcase
   endtask

   // Issues one op and checks done/busy every cycle until completion; while busy,
   // inputs are scrambled and stray starts are driven, all of which must be ignored.
   task automatic do_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        input bit lit_en, input logic [31:0] lit);
      logic [31:0] er;
      logic        ee;
      int          lat;
      model(c, a, b, er, ee, lat);
      @(negedge clk);
      start = 1'b1; ULActl = c; A = a; B = b;
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         chk($sformatf("done op=%b k=%0d", c, k), 32'(done), 32'(k == lat));
         chk($sformatf("busy op=%b k=%0d", c, k), 32'(busy), 32'(k < lat));
         if (k == lat) begin
            chk($sformatf("result op=%b a=%h b=%h", c, a, b), result, er);
            chk($sformatf("zero op=%b", c), 32'(zero), 32'(er == '0));
            chk($sformatf("erro op=%b", c), 32'(erro), 32'(ee));
            if (lit_en) chk($sformatf("literal op=%b a=%h b=%h", c, a, b), result, lit);
            start = 1'b0;
         end else begin
            @(negedge clk);
            start  = (k == 4) ? 1'b1 : 1'($urandom_range(0, 1));
            ULActl = 5'($urandom);
            A      = $urandom;
            B      = $urandom;
         end
      end
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return 32'd1;
         2: return '1;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         5: return 32'($urandom_range(0, 40));
         6: return -32'($urandom_range(1, 40));
         default: return $urandom;
      endcase
   endfunction

   logic [4:0] codes [17] = '{5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00111, 5'b10000,
                              5'b01010, 5'b01011, 5'b01101, 5'b01111, 5'b01100, 5'b01000,
                              5'b01110, 5'b00011, 5'b00100, 5'b00101, 5'b01001};

   initial begin
      rst_n = 1'b0; start = 1'b0; ULActl = '0; A = '0; B = '0;
      repeat (2) @(negedge clk);
      chk("reset result", result, 32'h0);
      chk("reset zero",   32'(zero), 32'h0);
      chk("reset done",   32'(done), 32'h0);
      chk("reset busy",   32'(busy), 32'h0);
      chk("reset erro",   32'(erro), 32'h0);
      rst_n = 1'b1;

      // Abort a multiply mid-flight with reset
      @(negedge clk); start = 1'b1; ULActl = 5'b00100; A = 32'hFFFFFFFD; B = 32'd7;
      @(negedge clk); start = 1'b0;
      repeat (8) @(negedge clk);
      chk("busy mid mul", 32'(busy), 32'h1);
      #2 rst_n = 1'b0; #1;
      chk("abort result", result, 32'h0);
      chk("abort done",   32'(done), 32'h0);
      chk("abort busy",   32'(busy), 32'h0);
      chk("abort erro",   32'(erro), 32'h0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("post-abort done", 32'(done), 32'h0);
         chk("post-abort busy", 32'(busy), 32'h0);
      end

      do_op(5'b00010, 32'd7,        32'hFFFFFFF9, 1, 32'h0);
      do_op(5'b00111, 32'hFFFFFFFF, 32'd1,        1, 32'h1);
      do_op(5'b10000, 32'd5,        32'd5,        1, 32'h1);
      do_op(5'b01010, 32'd5,        32'd5,        1, 32'h0);
      do_op(5'b01111, 32'd3,        32'd4,        1, 32'h1);
      do_op(5'b01110, 32'd1,        32'd37,       1, 32'h20);
      do_op(5'b00011, 32'h80000000, 32'd31,       1, 32'h1);
      do_op(5'b01000, 32'h0,        32'h1234,     1, 32'h12340000);
      do_op(5'b00100, 32'hFFFFFFFD, 32'd7,        1, 32'hFFFFFFEB);
      do_op(5'b00101, 32'hFFFFFFF9, 32'd2,        1, 32'hFFFFFFFD);
      do_op(5'b01001, 32'hFFFFFFF9, 32'd2,        1, 32'hFFFFFFFF);
      do_op(5'b00101, 32'd5,        32'd0,        1, 32'hFFFFFFFF);
      do_op(5'b01001, 32'hFFFFFFFB, 32'd0,        1, 32'hFFFFFFFB);
      do_op(5'b00101, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
      do_op(5'b01001, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0);
      do_op(5'b11111, 32'd9,        32'd9,        1, 32'h0);
      do_op(5'b00010, 32'd2,        32'd3,        1, 32'h5);

      for (int n = 0; n < 80; n++) begin
         logic [4:0] c;
         c = ($urandom_range(0, 7) == 0) ? 5'($urandom) : codes[$urandom_range(0, 16)];
         do_op(c, rnd_opnd(), rnd_opnd(), 0, 32'h0);
      end

      @(posedge clk); #1;
      chk("idle done", 32'(done), 32'h0);
      chk("idle busy", 32'(busy), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
